uart_tx_cfg: RTL and testbench

Parametrised asynchronous UART transmitter, successor to the fixed 8N1 transmitter.
- Configurable data width, parity mode and stop-bit count.
- Internal baud divider and a valid/ready input handshake.
- Optional input FIFO so a host can queue bytes back-to-back.
- Sits between a byte producer (echo logic, command responder) and the board TX pin.

---
 rtl/uart_tx_cfg.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg
//   Parametrised asynchronous UART transmitter. Each frame is a start bit,
//   DATA_BITS data bits sent LSB first, an optional parity bit and STOP_BITS
//   stop bits. Every bit lasts DIV = (CLK_FREQ + BAUD/2) / BAUD clocks.
//
//   Optional feature macro: UART_TX_FIFO_EN
//     defined   : a FIFO_DEPTH-entry FIFO buffers words in front of the FSM,
//                 tx_ready = FIFO not full, fifo_level = occupancy
//     undefined : words are taken directly in IDLE, fifo_level tied to 0
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   tx_valid    producer has a word on tx_data
//   tx_data     word to send, LSB first
//   tx_ready    word is accepted this cycle when tx_valid is high
//   tx          registered serial line output, idle high
//   tx_busy     a frame is on the line
//   fifo_level  FIFO occupancy (0 without the FIFO)

module uart_tx_cfg #(
  parameter int unsigned CLK_FREQ   = 12000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned DIV      = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned STOP_LEN = STOP_BITS * DIV;
  localparam int unsigned CW       = (STOP_LEN > 1) ? $clog2(STOP_LEN) : 1;
  localparam int unsigned BW       = $clog2(DATA_BITS);
  // PARITY=3 (undefined) falls back to no parity.
  localparam bit          PAR_EN   = (PARITY == 1) || (PARITY == 2);
  localparam bit          PAR_ODD  = (PARITY == 1);

  localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_M1  = CW'(STOP_LEN - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  // Elaboration-time parameter checks
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_cfg: CLK_FREQ/BAUD must give at least 2 clocks per bit");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   rdy_en_q;

  // Word source for the FSM: direct from the port or from the FIFO head.
  logic                   load_req;
  logic [DATA_BITS-1:0]   load_word;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2 >= 2");
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;
  logic                 push, pop, full, empty;

  // Full/empty come from the level counter; the pointers simply wrap.
  assign full      = (level == LW'(FIFO_DEPTH));
  assign empty     = (level == '0);
  assign tx_ready  = rdy_en_q && !full;
  assign push      = tx_valid && tx_ready;
  assign pop       = (state_q == S_IDLE) && !empty;
  assign load_req  = pop;
  assign load_word = mem[rd_ptr];
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
`else
  assign tx_ready   = rdy_en_q && (state_q == S_IDLE);
  assign load_req   = tx_valid && tx_ready;
  assign load_word  = tx_data;
  assign fifo_level = '0;
`endif

  assign tx      = tx_q;
  assign tx_busy = (state_q != S_IDLE);

  // Next-state and datapath. tx_d is the line value for the state being
  // entered, so the registered line changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (load_req) begin
          state_d = S_START;
          tx_d    = 1'b0;
          shreg_d = load_word;
          par_d   = PAR_ODD ? ~(^load_word) : ^load_word;
          bit_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == DIV_M1) begin
          state_d = S_DATA;
          cnt_d   = '0;
          tx_d    = shreg_q[0];
        end
      end

      S_DATA: begin
        if (cnt_q == DIV_M1) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            if (PAR_EN) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // shreg_q[0] is on the line; its successor is shreg_q[1].
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end

      S_PARITY: begin
        if (cnt_q == DIV_M1) begin
          state_d = S_STOP;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == STOP_M1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          tx_d    = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      // Holds tx_ready low until the first edge after reset release.
      rdy_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: several instances with different frame formats
// share clk/rst. Expected line waveforms come from a frame-level model.

module tb_uart_tx_cfg;

  localparam int N = 6;
`ifdef UART_TX_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] v   = '0;
  logic [8:0]   d [N];
  wire  [N-1:0] txo, busy, rdy;
  wire  [4:0]   lvl0, lvl1, lvl2, lvl3, lvl4;
  wire  [2:0]   lvl5;

  int checks = 0;
  int fails  = 0;
  bit line_s [1024];
  int last_busy;

  always #5 clk = ~clk;

  // inst0: 8N1 DIV12   inst1: 8E1 DIV12   inst2: 8O1 DIV12
  // inst3: 7N2 DIV12   inst4: 9 bits PARITY=3 2 stop DIV2   inst5: 8N1 DIV2 FIFO 4
  uart_tx_cfg #(.CLK_FREQ(12000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
    .clk(clk), .rst(rst), .tx_valid(v[0]), .tx_data(d[0][7:0]), .tx_ready(rdy[0]),
    .tx(txo[0]), .tx_busy(busy[0]), .fifo_level(lvl0));
  uart_tx_cfg #(.CLK_FREQ(12000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(2),
                .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
    .clk(clk), .rst(rst), .tx_valid(v[1]), .tx_data(d[1][7:0]), .tx_ready(rdy[1]),
    .tx(txo[1]), .tx_busy(busy[1]), .fifo_level(lvl1));
  uart_tx_cfg #(.CLK_FREQ(12000000), .BAUD(1000000), .DATA_BITS(8), .PARITY(1),
                .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
    .clk(clk), .rst(rst), .tx_valid(v[2]), .tx_data(d[2][7:0]), .tx_ready(rdy[2]),
    .tx(txo[2]), .tx_busy(busy[2]), .fifo_level(lvl2));
  uart_tx_cfg #(.CLK_FREQ(12000000), .BAUD(1000000), .DATA_BITS(7), .PARITY(0),
                .STOP_BITS(2), .FIFO_DEPTH(16)) u3 (
    .clk(clk), .rst(rst), .tx_valid(v[3]), .tx_data(d[3][6:0]), .tx_ready(rdy[3]),
    .tx(txo[3]), .tx_busy(busy[3]), .fifo_level(lvl3));
  uart_tx_cfg #(.CLK_FREQ(12000000), .BAUD(5000000), .DATA_BITS(9), .PARITY(3),
                .STOP_BITS(2), .FIFO_DEPTH(16)) u4 (
    .clk(clk), .rst(rst), .tx_valid(v[4]), .tx_data(d[4]), .tx_ready(rdy[4]),
    .tx(txo[4]), .tx_busy(busy[4]), .fifo_level(lvl4));
  uart_tx_cfg #(.CLK_FREQ(12000000), .BAUD(5000000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(4)) u5 (
    .clk(clk), .rst(rst), .tx_valid(v[5]), .tx_data(d[5][7:0]), .tx_ready(rdy[5]),
    .tx(txo[5]), .tx_busy(busy[5]), .fifo_level(lvl5));

  // ---------------- frame-level reference model ----------------
  function automatic int div_of(input int i);
    int baud;
    baud = (i == 4 || i == 5) ? 5000000 : 1000000;
    return (12000000 + baud / 2) / baud;
  endfunction
  function automatic int db_of(input int i);
    return (i == 3) ? 7 : (i == 4) ? 9 : 8;
  endfunction
  function automatic int par_of(input int i);
    return (i == 1) ? 2 : (i == 2) ? 1 : (i == 4) ? 3 : 0;
  endfunction
  function automatic int sb_of(input int i);
    return (i == 3 || i == 4) ? 2 : 1;
  endfunction
  function automatic bit has_par(input int i);
    return par_of(i) == 1 || par_of(i) == 2;
  endfunction
  function automatic int frame_len(input int i);
    return (1 + db_of(i) + (has_par(i) ? 1 : 0) + sb_of(i)) * div_of(i);
  endfunction
  // Expected line level k clocks into a frame carrying word w.
  function automatic bit exp_line(input int i, input logic [8:0] w, input int k);
    int slot;
    bit p;
    slot = k / div_of(i);
    if (slot == 0) return 1'b0;
    if (slot <= db_of(i)) return w[slot-1];
    if (has_par(i) && slot == db_of(i) + 1) begin
      p = 1'b0;
      for (int b = 0; b < db_of(i); b++) p = p ^ w[b];
      return (par_of(i) == 1) ? ~p : p;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at the first sample after the frame starts (START entered).
  task automatic check_frame(input int i, input logic [8:0] w);
    int fl, bad, bad_k, bsy, rbad;
    fl = frame_len(i); bad = 0; bad_k = -1; bsy = 0; rbad = 0;
    for (int k = 0; k < fl; k++) begin
      line_s[k] = txo[i];
      if (txo[i] !== exp_line(i, w, k)) begin
        if (bad == 0) bad_k = k;
        bad++;
      end
      if (busy[i] === 1'b1) bsy++;
      if (rdy[i] !== FIFO) rbad++;
      @(posedge clk); #1;
    end
    last_busy = bsy;
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL frame inst%0d word %0h: got %0d wrong samples (first at clk %0d) expected 0",
               i, w, bad, bad_k);
    end
    chk("ready_during_frame_errors", rbad, 0);
    chk("idle_after_frame_tx_busy_ready", {txo[i], busy[i], rdy[i]}, 3'b101);
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (rdy[i] !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", rdy[i], 1'b1);
  endtask

  task automatic send(input int i, input logic [8:0] w);
    v[i] = 1'b1;
    d[i] = w;
    wait_ready(i);
    @(posedge clk); #1;
    v[i] = 1'b0;
    d[i] = 9'($urandom);      // must not disturb the frame in flight
    if (FIFO) begin
      @(posedge clk); #1;     // pop cycle before START
    end
    check_frame(i, w);
  endtask

  typedef struct {
    int         inst;
    logic [8:0] word;
    int         exp_len;
    bit         chk_par;
    bit         exp_par;
  } vec_t;
  vec_t tbl [7];

  bit        mon_en = 1'b0;
  bit        mon_q [$];
  always @(negedge clk) if (mon_en) mon_q.push_back(txo[5]);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no $finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 9'h0A5, 120, 1'b0, 1'b0};
    tbl[1] = '{1, 9'h0A5, 132, 1'b1, 1'b0};
    tbl[2] = '{2, 9'h0A5, 132, 1'b1, 1'b1};
    tbl[3] = '{1, 9'h001, 132, 1'b1, 1'b1};
    tbl[4] = '{3, 9'h055, 120, 1'b0, 1'b0};
    tbl[5] = '{4, 9'h1A5, 24,  1'b0, 1'b0};
    tbl[6] = '{2, 9'h0FF, 132, 1'b1, 1'b1};
    for (int i = 0; i < N; i++) d[i] = '0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", txo, {N{1'b1}});
    chk("reset_busy", busy, '0);
    chk("reset_ready", rdy, '0);
    chk("reset_level", {lvl0, lvl1, lvl2, lvl3, lvl4, lvl5}, '0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("ready_before_first_edge", rdy, '0);
    @(posedge clk); #1;
    chk("ready_after_reset", rdy, {N{1'b1}});

    // directed frames
    for (int t = 0; t < 7; t++) begin
      send(tbl[t].inst, tbl[t].word);
      chk("busy_len", last_busy, tbl[t].exp_len);
      if (tbl[t].chk_par)
        chk("parity_bit", line_s[(1 + db_of(tbl[t].inst)) * div_of(tbl[t].inst)
                                 + div_of(tbl[t].inst) / 2], tbl[t].exp_par);
    end

`ifndef UART_TX_FIFO_EN
    // back-to-back with tx_valid held high, data changed mid-frame
    v[0] = 1'b1;
    d[0] = 9'h011;
    chk("b2b_ready", rdy[0], 1'b1);
    @(posedge clk); #1;
    d[0] = 9'h022;
    check_frame(0, 9'h011);
    @(posedge clk); #1;
    v[0] = 1'b0;
    d[0] = 9'h0AA;
    check_frame(0, 9'h022);
`endif

    // asynchronous reset in the middle of a 0x00 frame
    v[0] = 1'b1;
    d[0] = 9'h000;
    wait_ready(0);
    @(posedge clk); #1;
    v[0] = 1'b0;
    if (FIFO) begin
      @(posedge clk); #1;
    end
    repeat (49) @(posedge clk);
    #3;
    chk("pre_reset_line_low", txo[0], 1'b0);
    rst = 1'b1;
    #1;
    chk("async_reset_tx", txo[0], 1'b1);
    chk("async_reset_busy", busy[0], 1'b0);
    chk("async_reset_ready", rdy[0], 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("post_reset_ready_low", rdy[0], 1'b0);
    @(posedge clk); #1;
    chk("post_reset_ready_high", rdy[0], 1'b1);
    send(0, 9'h00F);

    // randomized frames across formats
    for (int r = 0; r < 40; r++) begin
      int i, gap;
      i = $urandom_range(0, 4);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      send(i, 9'($urandom));
    end

`ifdef UART_TX_FIFO_EN
    begin
      logic [7:0] fw [6];
      int         starts [$];
      int         fl, idx, bad;
      logic [8:0] w;
      fw[0] = 8'h3C; fw[1] = 8'hA5; fw[2] = 8'h01; fw[3] = 8'hFE; fw[4] = 8'h5A; fw[5] = 8'h80;
      mon_en = 1'b1;
      for (int j = 0; j < 6; j++) begin
        v[5] = 1'b1;
        d[5] = {1'b0, fw[j]};
        wait_ready(5);
        @(posedge clk); #1;
        if (j == 4) begin
          chk("fifo_level_full", lvl5, 3'd4);
          chk("fifo_ready_full", rdy[5], 1'b0);
        end
      end
      v[5] = 1'b0;
      repeat (6 * 21 + 20) @(posedge clk);
      #1;
      mon_en = 1'b0;
      chk("fifo_level_empty", lvl5, 3'd0);
      chk("fifo_busy_end", busy[5], 1'b0);
      fl = frame_len(5);
      idx = 0;
      while (idx + fl <= mon_q.size()) begin
        if (mon_q[idx] == 1'b0) begin
          w = (starts.size() < 6) ? {1'b0, fw[starts.size()]} : 9'h000;
          bad = 0;
          for (int k = 0; k < fl; k++) if (mon_q[idx+k] != exp_line(5, w, k)) bad++;
          chk("fifo_frame_samples", bad, 0);
          starts.push_back(idx);
          idx = idx + fl;
        end else begin
          idx++;
        end
      end
      chk("fifo_frame_count", starts.size(), 6);
      for (int j = 1; j < starts.size(); j++)
        chk("fifo_gap", starts[j] - starts[j-1], fl + 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
